// File: rtl/can_tx_scheduler_if.sv
// Mailbox-to-transmitter bundle for the CAN transmit scheduler.
// master is the scheduler side, slave is the mailbox/transmitter side.
interface can_tx_scheduler_if #(
    parameter int NUM_MB = 4
);
    logic [NUM_MB-1:0]    req;
    logic [11*NUM_MB-1:0] req_id;
    logic [64*NUM_MB-1:0] req_data;
    logic                 rxing;
    logic                 txing;
    logic                 tx_ok;
    logic                 tx_fail;
    logic [10:0]          address;
    logic [63:0]          data;
    logic                 send_data;
    logic                 busy;
    logic [2:0]           grant_idx;
    logic [NUM_MB-1:0]    done;
    logic [NUM_MB-1:0]    err;

    modport master (
        input  req, req_id, req_data,
        input  rxing, txing, tx_ok, tx_fail,
        output address, data, send_data,
        output busy, grant_idx, done, err
    );

    modport slave (
        output req, req_id, req_data,
        output rxing, txing, tx_ok, tx_fail,
        input  address, data, send_data,
        input  busy, grant_idx, done, err
    );
endinterface

// File: rtl/can_tx_scheduler.sv
// Priority scheduler sharing one CAN transmitter among NUM_MB mailboxes.
// Lowest identifier wins; failed frames retry up to RETRY_MAX times.
module can_tx_scheduler #(
    parameter int NUM_MB        = 4,
    parameter int RETRY_MAX     = 8,
    parameter int IFS_CYCLES    = 16,
    parameter int START_TIMEOUT = 1024
) (
    input logic                 clk,
    input logic                 rst,
    can_tx_scheduler_if.master  bus
);
    localparam int TW = $clog2(START_TIMEOUT + 1);
    localparam int GW = $clog2(IFS_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(START_TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(IFS_CYCLES - 1);
    localparam logic [3:0]    RMAX     = 4'(RETRY_MAX);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_START,
        ACTIVE,
        GAP
    } state_t;

    state_t state, state_nx;

    logic [TW-1:0]     to_cnt;
    logic [GW-1:0]     gap_cnt;
    logic [3:0]        retry_cnt [NUM_MB];
    logic [10:0]       address_q;
    logic [63:0]       data_q;
    logic [2:0]        grant_q;
    logic [NUM_MB-1:0] done_q;
    logic [NUM_MB-1:0] err_q;

    logic        found;
    logic [10:0] win_id;
    logic [63:0] win_data;
    logic [2:0]  win_idx;
    logic        launch;
    logic        att_ok;
    logic        att_fail;

    // Strict less-than keeps the lowest index on equal identifiers.
    always_comb begin
        found    = 1'b0;
        win_id   = '0;
        win_data = '0;
        win_idx  = '0;
        for (int i = 0; i < NUM_MB; i++) begin
            if (bus.req[i] &&
                (!found || bus.req_id[11*i +: 11] < win_id)) begin
                found    = 1'b1;
                win_id   = bus.req_id[11*i +: 11];
                win_data = bus.req_data[64*i +: 64];
                win_idx  = 3'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        launch   = 1'b0;
        att_ok   = 1'b0;
        att_fail = 1'b0;
        unique case (state)
            IDLE: begin
                if (!bus.rxing && found) begin
                    launch   = 1'b1;
                    state_nx = LAUNCH;
                end
            end
            LAUNCH: state_nx = WAIT_START;
            WAIT_START: begin
                if (bus.txing) begin
                    state_nx = ACTIVE;
                end else if (to_cnt == TO_LAST) begin
                    att_fail = 1'b1;
                    state_nx = GAP;
                end
            end
            ACTIVE: begin
                if (bus.tx_ok) begin
                    att_ok   = 1'b1;
                    state_nx = GAP;
                end else if (bus.tx_fail || !bus.txing) begin
                    att_fail = 1'b1;
                    state_nx = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt  <= '0;
            gap_cnt <= '0;
        end else begin
            if (state == LAUNCH)
                to_cnt <= '0;
            else if (state == WAIT_START)
                to_cnt <= to_cnt + 1'b1;
            if (state == GAP)
                gap_cnt <= gap_cnt + 1'b1;
            else
                gap_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            address_q <= '0;
            data_q    <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            err_q     <= '0;
            for (int i = 0; i < NUM_MB; i++)
                retry_cnt[i] <= '0;
        end else begin
            done_q <= '0;
            err_q  <= '0;
            if (launch) begin
                address_q <= win_id;
                data_q    <= win_data;
                grant_q   <= win_idx;
            end
            for (int i = 0; i < NUM_MB; i++) begin
                if (grant_q == 3'(i)) begin
                    if (att_ok) begin
                        done_q[i]    <= 1'b1;
                        retry_cnt[i] <= '0;
                    end else if (att_fail) begin
                        if (retry_cnt[i] + 4'd1 == RMAX) begin
                            err_q[i]     <= 1'b1;
                            retry_cnt[i] <= '0;
                        end else begin
                            retry_cnt[i] <= retry_cnt[i] + 4'd1;
                        end
                    end
                end
            end
        end
    end

    assign bus.address   = address_q;
    assign bus.data      = data_q;
    assign bus.grant_idx = grant_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.send_data = (state == LAUNCH);
    assign bus.busy      = (state != IDLE);
endmodule

// File: doc/can_tx_scheduler.md
# can_tx_scheduler

Transmit scheduler that shares the single CAN transmit path among `NUM_MB` transmit mailboxes. It arbitrates pending mailboxes by CAN priority (lowest 11-bit identifier wins), presents the winner's identifier and payload to the transmitter, and issues the `send_data` launch strobe. It then tracks the frame through `txing` and the completion status pulses, retries failed frames, and reports per-mailbox done/error. It sits between the host-side mailbox registers and the transmit container.

## Interface
Parameters:
- `NUM_MB`, 4: number of mailboxes; legal range 2..8.
- `RETRY_MAX`, 8: failed attempts allowed per mailbox before `err` is raised; legal range 1..15.
- `IFS_CYCLES`, 16: idle `clk` cycles enforced after every attempt; legal range ≥ 1.
- `START_TIMEOUT`, 1024: `clk` cycles allowed from launch to `txing` rising.

Ports:
- `clk`  in  1  system clock; the block's only clock.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NUM_MB  mailbox i has a frame pending; held high by the requester until `done[i]` or `err[i]`.
- `req_id`  in  11*NUM_MB  identifier of mailbox i at bits [11i+10:11i].
- `req_data`  in  64*NUM_MB  payload of mailbox i at bits [64i+63:64i].
- `rxing`  in  1  bus busy receiving; no new launch while high.
- `txing`  in  1  transmitter active.
- `tx_ok`  in  1  one-cycle pulse: frame sent and acknowledged.
- `tx_fail`  in  1  one-cycle pulse: arbitration lost or error frame.
- `address`  out  11  identifier to the transmitter.
- `data`  out  64  payload to the transmitter.
- `send_data`  out  1  one-cycle launch strobe.
- `busy`  out  1  scheduler owns the transmitter.
- `grant_idx`  out  3  index of the mailbox in flight.
- `done`  out  NUM_MB  one-cycle success pulse per mailbox.
- `err`  out  NUM_MB  one-cycle retry-exhausted pulse per mailbox.

## Operation
- States: IDLE, LAUNCH, WAIT_START, ACTIVE, GAP.
- IDLE:
  - `req` is sampled only in this state, and only if `rxing` is 0 and `req` is nonzero.
  - Winner: the requesting mailbox with the lowest `req_id`; equal IDs go to the lowest index.
  - The winner's ID, payload and index are latched into `address`, `data` and `grant_idx`. Next state is LAUNCH.
- LAUNCH:
  - `send_data` is 1 for exactly this cycle.
  - The timeout counter is cleared. Next state is WAIT_START.
- WAIT_START:
  - `txing` = 1 moves to ACTIVE.
  - If the counter reaches `START_TIMEOUT` first, the attempt is a failure.
- ACTIVE:
  - `tx_ok` marks success: `done[grant_idx]` pulses and `retry_cnt[grant_idx]` is cleared.
  - `tx_fail`, or `txing` falling with neither status pulse present, marks a failure.
- Failure handling:
  - `retry_cnt[grant_idx]` is incremented.
  - If the new value equals `RETRY_MAX`, `err[grant_idx]` pulses and the count is cleared.
  - The failed mailbox is re-arbitrated on the next IDLE if it still requests.
- Every attempt, success or failure, ends in GAP. GAP counts `IFS_CYCLES` and then returns to IDLE.
- Retry counters are per mailbox, 4 bits each. They are not cleared when another mailbox wins.
- `tx_ok` and `tx_fail` in the same cycle: `tx_ok` wins.
- `tx_ok` or `tx_fail` arriving outside ACTIVE is ignored.
- If `req[grant_idx]` drops mid-flight, the attempt still completes and `done`/`err` still pulses.
- `rxing` rising after LAUNCH does not abort the attempt; arbitration loss arrives via `tx_fail`.

## Timing
- Reset values: state IDLE; `address` 0, `data` 0, `send_data` 0, `busy` 0, `grant_idx` 0, `done` 0, `err` 0; all counters 0.
- Reset asserted in any state returns to IDLE on the next edge. No `done` or `err` pulse is issued for the aborted attempt.
- Launch latency: `req` seen in IDLE at edge N gives `send_data` = 1 in cycle N+1.
- `address`, `data` and `grant_idx` are valid from cycle N+1 and stay stable until the next IDLE exit.
- `busy` is 1 in every state except IDLE.
- `done` and `err` pulse in the cycle after the status is detected, coincident with entry to GAP.
- Minimum attempt-to-attempt spacing: `IFS_CYCLES` + 3 cycles.

## Test plan
- Single request: `req`=0001, `req_id[0]`=0x123 → one `send_data` pulse, `address`=0x123; `txing` high 10 cycles, then `tx_ok` → `done`=0001 once; `busy` low 16 cycles after GAP entry.
- Priority: `req`=1111 with IDs 0x400, 0x0FF, 0x0FF, 0x7FF → `grant_idx`=1 first, then 2, 3's predecessor 0 (0x400), then 3, each after its `tx_ok`.
- Retry exhaustion: mailbox 2 only, `tx_fail` on every attempt → exactly 8 launches, then `err`=0100 and no `done`.
- Start timeout: `txing` never rises → failure counted after 1024 cycles in WAIT_START; with `RETRY_MAX`=1, `err` pulses.
- Bus busy and collisions: `rxing`=1 while `req`=0001 → no launch until `rxing` falls. Simultaneous `tx_ok` and `tx_fail` → `done` only.
- Mid-flight reset: assert `rst` in ACTIVE → next cycle all outputs 0, state IDLE, and no `done`/`err` pulse.
